pin_drive_sched: RTL

- Time-shares the testbench pin vector between several requesters (sequences, reset/strap drivers, interrupt injectors).
- Each requester asks to drive a masked value onto the pins for a programmed number of cycles.
- The scheduler grants one requester at a time in round-robin order, drives the masked bits with output-enable for the hold time, then releases them.
- Its outputs feed the pin vector and its per-bit enables.

---
 rtl/pin_drive_sched.sv | 89 ++++++++
 1 files changed

// File: rtl/pin_drive_sched.sv
// pin_drive_sched: round-robin owner of a shared pin vector; the granted requester
// drives its masked bits with output-enable for its hold time, then releases them.
`ifndef PIN_MAX
`define PIN_MAX 32
`endif
module pin_drive_sched #(
    parameter int NUM_REQ = 4,
    parameter int PIN_W   = `PIN_MAX,
    parameter int HOLD_W  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*PIN_W-1:0]     req_mask,
    input  logic [NUM_REQ*PIN_W-1:0]     req_value,
    input  logic [NUM_REQ*HOLD_W-1:0]    req_hold,
    output logic [PIN_W-1:0]             pins_out,
    output logic [PIN_W-1:0]             pins_oe,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   gnt_id,
    output logic                         done
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
    state_t             state_q;
    logic [PIN_W-1:0]   pins_out_q, pins_oe_q, mask_q, mask_d, value_d;
    logic [HOLD_W-1:0]  cnt_q, cnt_d, hold_d;
    logic [IW-1:0]      rr_q, gnt_q, win_d;
    logic               done_q, any_d;
    function automatic logic [IW-1:0] wrap(input int v);
        return IW'(v % NUM_REQ);
    endfunction
    // Scan downward so the candidate closest to rr_q is the last (winning) assignment.
    always_comb begin
        win_d = '0;
        any_d = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrap(int'(rr_q) + k)]) begin
                win_d = wrap(int'(rr_q) + k);
                any_d = 1'b1;
            end
        end
    end
    assign mask_d    = req_mask[win_d*PIN_W +: PIN_W];
    assign value_d   = req_value[win_d*PIN_W +: PIN_W];
    assign hold_d    = req_hold[win_d*HOLD_W +: HOLD_W];
    assign cnt_d     = (hold_d == '0) ? '0 : hold_d - 1'b1;
    assign req_ready = (state_q == IDLE && !rst && any_d) ? NUM_REQ'(1) << win_d : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pins_out_q <= '0;
            pins_oe_q  <= '0;
            mask_q     <= '0;
            cnt_q      <= '0;
            rr_q       <= '0;
            gnt_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (any_d) begin
                    mask_q     <= mask_d;
                    gnt_q      <= win_d;
                    pins_out_q <= (pins_out_q & ~mask_d) | (value_d & mask_d);
                    pins_oe_q  <= pins_oe_q | mask_d;
                    cnt_q      <= cnt_d;
                    rr_q       <= (win_d == IW'(NUM_REQ - 1)) ? '0 : win_d + 1'b1;
                    state_q    <= DRIVE;
                end
                DRIVE: if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    pins_oe_q <= pins_oe_q & ~mask_q;
                    done_q    <= 1'b1;
                    state_q   <= GAP;
                end
                GAP:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign pins_out = pins_out_q;
    assign pins_oe  = pins_oe_q;
    assign busy     = state_q != IDLE;
    assign gnt_id   = gnt_q;
    assign done     = done_q;
endmodule
